hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, number of in-flight instruction slots tracked (power of two, >= 2).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 id_valid_i  input  1  ID holds a valid instruction for EX.
REQ-005 id_ack_i  input  1  EX accepted the ID instruction this cycle (ID->EX handshake).
REQ-006 id_rd_i / id_rs1_i / id_rs2_i  input  5 each  destination and source register indices of the ID instruction.
REQ-007 id_we_i / id_use_rs1_i / id_use_rs2_i  input  1 each  ID instruction writes rd / reads rs1 / reads rs2.
REQ-008 id_fence_i  input  1  ID instruction is a fence (serialising).
REQ-009 ex_valid_i / ex_branch_i  input  1 each  EX output valid / EX output is a taken branch.
REQ-010 ex_result_i  input  32  EX result (branch target when ex_branch_i).
REQ-011 mem_ack_i  input  1  MEM accepted the EX output this cycle (EX->MEM handshake).
REQ-012 wb_retire_i  input  1  oldest in-flight instruction retired this cycle.
REQ-013 stall_o  output  1  hold ID; ID shall not present to EX.
REQ-014 flush_o  output  1  kill younger instructions in IF/ID/EX.
REQ-015 pc_redirect_o / pc_target_o  output  1 / 32  fetch redirect strobe / target.
REQ-016 inflight_o  output  log2(DEPTH)+1  current scoreboard occupancy.

Function
REQ-017 Scoreboard: FIFO of DEPTH entries {rd, we}, pointers rd_ptr (oldest), ex_ptr (next to leave EX), wr_ptr (next free), each log2(DEPTH)+1 bits, wrap modulo 2*DEPTH.
REQ-018 Push: id_valid_i & id_ack_i & !flush_o writes {id_rd_i, id_we_i & (id_rd_i != 0)} at wr_ptr, wr_ptr+1.
REQ-019 EX advance: ex_valid_i & mem_ack_i increments ex_ptr.
REQ-020 Pop: wb_retire_i increments rd_ptr; retire with empty scoreboard is ignored and no pointer moves.
REQ-021 Push, EX advance and pop in one cycle all take effect; occupancy = wr_ptr - rd_ptr.
REQ-022 RAW hazard: any valid entry with we=1 and rd equal to id_rs1_i (id_use_rs1_i) or id_rs2_i (id_use_rs2_i); rd=0 never matches.
REQ-023 stall_o combinational = id_valid_i & (hazard | full | state==FENCE | (id_fence_i & occupancy != 0)).
REQ-024 Hazard compare uses registered scoreboard only; an entry popped this cycle still stalls (one-cycle conservative).
REQ-025 flush_o = pc_redirect_o = ex_valid_i & ex_branch_i & mem_ack_i, combinational, same cycle; pc_target_o = ex_result_i then, else 0.
REQ-026 On flush: wr_ptr <= ex_ptr+1 (keep branch and older); same-cycle push discarded; same-cycle pop still applies.
REQ-027 FSM states RUN, FENCE; RUN->FENCE when id_valid_i & id_fence_i & occupancy != 0; FENCE->RUN when occupancy==0 (next-state value); FENCE holds stall_o=1.
REQ-028 flush_o in FENCE returns FSM to RUN next cycle.
REQ-029 Full (occupancy==DEPTH) with simultaneous pop: stall_o still 1 that cycle.

Reset
REQ-030 rst_i=1 at an edge: all pointers 0, FSM RUN, entries' we cleared; reset mid-operation discards all in-flight state.
REQ-031 During and after reset with inputs idle: stall_o=0, flush_o=0, pc_redirect_o=0, pc_target_o=0, inflight_o=0.

Structure
REQ-032 FSM state enum and SB_DEPTH default constant belong in shared package core_pkg.
REQ-033 Storage, pointers and comparators form sub-module hazard_scoreboard; FSM and flush/stall logic stay in hazard_ctrl.

Verification
REQ-034 Push rd=5 we=1, next ID reads rs1=5 -> stall_o=1 until that entry retires; rs1=0 with rd=0 -> no stall.
REQ-035 Four pushes without retire (DEPTH=4) -> inflight_o=4, stall_o=1; one retire -> inflight_o=3, stall releases next cycle.
REQ-036 Branch handshake, target 0x0000_0100, with same-cycle ID push -> flush_o=1, pc_target_o=0x100, push dropped, inflight_o excludes younger.
REQ-037 Fence at ID with 2 in flight -> FENCE state, stall_o=1 for exactly 2 retire events, then RUN.
REQ-038 rst_i asserted with 3 entries and state FENCE -> next cycle inflight_o=0, stall_o=0, RUN.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types and constants.
// Hazard FSM states and scoreboard default depth.
package core_pkg;

  localparam int SB_DEPTH = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FENCE = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard.
// FIFO of {rd, we} with oldest/EX/free pointers and RAW compare.
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [4:0]    rd_i,
  input  logic          we_i,
  input  logic          ex_adv_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic          use_rs1_i,
  input  logic          use_rs2_i,
  output logic          hazard_o,
  output logic [PW-1:0] count_o,
  output logic [PW-1:0] count_nxt_o
);

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    ex_ptr_q, ex_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];
  logic [DEPTH-1:0] we_q, we_d;
  logic             pop_ok;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign pop_ok  = pop_i & (count_o != '0);

  // Pointer and entry next-state; flush keeps the branch and older.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    ex_ptr_d = ex_ptr_q + PW'(ex_adv_i);
    rd_d     = rd_q;
    we_d     = we_q;
    if (flush_i) begin
      wr_ptr_d = ex_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push_i);
    end
    if (push_i && !flush_i) begin
      rd_d[wr_ptr_q[AW-1:0]] = rd_i;
      we_d[wr_ptr_q[AW-1:0]] = we_i & (rd_i != 5'd0);
    end
  end

  assign count_nxt_o = wr_ptr_d - rd_ptr_d;

  // RAW compare against registered entries only.
  always_comb begin
    logic [AW-1:0] off;
    logic          vld;
    hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q[AW-1:0];
      vld = {1'b0, off} < count_o;
      if (vld && we_q[i] && (rd_q[i] != 5'd0) &&
          ((use_rs1_i && (rd_q[i] == rs1_i)) ||
           (use_rs2_i && (rd_q[i] == rs2_i)))) begin
        hazard_o = 1'b1;
      end
    end
  end

  // State update; reset drops every in-flight entry.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      ex_ptr_q <= '0;
      wr_ptr_q <= '0;
      we_q     <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= 5'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      ex_ptr_q <= ex_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      we_q     <= we_d;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller.
// Stall on RAW/full/fence, flush and redirect on taken branch.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          id_valid_i,
  input  logic          id_ack_i,
  input  logic [4:0]    id_rd_i,
  input  logic [4:0]    id_rs1_i,
  input  logic [4:0]    id_rs2_i,
  input  logic          id_we_i,
  input  logic          id_use_rs1_i,
  input  logic          id_use_rs2_i,
  input  logic          id_fence_i,
  input  logic          ex_valid_i,
  input  logic          ex_branch_i,
  input  logic [31:0]   ex_result_i,
  input  logic          mem_ack_i,
  input  logic          wb_retire_i,
  output logic          stall_o,
  output logic          flush_o,
  output logic          pc_redirect_o,
  output logic [31:0]   pc_target_o,
  output logic [PW-1:0] inflight_o
);

  hz_state_e     state_q;
  logic          hazard;
  logic          full;
  logic          push;
  logic          ex_adv;
  logic [PW-1:0] count_nxt;

  assign ex_adv        = ex_valid_i & mem_ack_i;
  assign flush_o       = ex_adv & ex_branch_i;
  assign pc_redirect_o = flush_o;
  assign pc_target_o   = flush_o ? ex_result_i : 32'd0;
  assign push          = id_valid_i & id_ack_i & ~flush_o;

  hazard_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk         (clk),
    .rst_i       (rst_i),
    .push_i      (push),
    .rd_i        (id_rd_i),
    .we_i        (id_we_i),
    .ex_adv_i    (ex_adv),
    .pop_i       (wb_retire_i),
    .flush_i     (flush_o),
    .rs1_i       (id_rs1_i),
    .rs2_i       (id_rs2_i),
    .use_rs1_i   (id_use_rs1_i),
    .use_rs2_i   (id_use_rs2_i),
    .hazard_o    (hazard),
    .count_o     (inflight_o),
    .count_nxt_o (count_nxt)
  );

  assign full = inflight_o == PW'(DEPTH);

  // Hold ID on RAW, full, draining fence, or fence with work in flight.
  always_comb begin
    stall_o = id_valid_i &
              (hazard | full | (state_q == ST_FENCE) |
               (id_fence_i & (inflight_o != '0)));
  end

  // Fence FSM; a flush kills the fence and returns to RUN.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else if (flush_o) begin
      state_q <= ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (id_valid_i && id_fence_i && (inflight_o != '0)) begin
            state_q <= ST_FENCE;
          end
        end
        ST_FENCE: begin
          if (count_nxt == '0) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// Directed scenarios then random traffic against a queue model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        id_valid_i, id_ack_i;
  logic [4:0]  id_rd_i, id_rs1_i, id_rs2_i;
  logic        id_we_i, id_use_rs1_i, id_use_rs2_i, id_fence_i;
  logic        ex_valid_i, ex_branch_i;
  logic [31:0] ex_result_i;
  logic        mem_ack_i, wb_retire_i;
  logic        stall_o, flush_o, pc_redirect_o;
  logic [31:0] pc_target_o;
  logic [2:0]  inflight_o;

  always #5 clk = ~clk;

  hazard_ctrl #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_ack_i      (id_ack_i),
    .id_rd_i       (id_rd_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_we_i       (id_we_i),
    .id_use_rs1_i  (id_use_rs1_i),
    .id_use_rs2_i  (id_use_rs2_i),
    .id_fence_i    (id_fence_i),
    .ex_valid_i    (ex_valid_i),
    .ex_branch_i   (ex_branch_i),
    .ex_result_i   (ex_result_i),
    .mem_ack_i     (mem_ack_i),
    .wb_retire_i   (wb_retire_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .pc_redirect_o (pc_redirect_o),
    .pc_target_o   (pc_target_o),
    .inflight_o    (inflight_o)
  );

  typedef struct {
    int rd;
    bit we;
  } ent_t;

  ent_t q[$];
  int   nex;
  bit   fst;
  int   n_cmp = 0;
  int   n_bad = 0;

  bit        d_rst, d_iv, d_ia, d_we, d_u1, d_u2, d_fe;
  bit        d_exv, d_br, d_mack, d_ret;
  int        d_rd, d_rs1, d_rs2;
  bit [31:0] d_res;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_stall(bit iv, int rs1, int rs2,
                                 bit u1, bit u2, bit fe);
    bit haz = 0;
    foreach (q[i]) begin
      if (q[i].we && q[i].rd != 0 &&
          ((u1 && q[i].rd == rs1) || (u2 && q[i].rd == rs2)))
        haz = 1;
    end
    return iv && (haz || q.size() == 4 || fst ||
                  (fe && q.size() != 0));
  endfunction

  task automatic idle();
    d_rst = 0; d_iv = 0; d_ia = 0; d_we = 0;
    d_u1 = 0; d_u2 = 0; d_fe = 0;
    d_exv = 0; d_br = 0; d_mack = 0; d_ret = 0;
    d_rd = 0; d_rs1 = 0; d_rs2 = 0; d_res = 0;
  endtask

  // One cycle: drive, compare against model, advance model.
  task automatic step();
    bit fl, adv, psh, pop, st;
    int occ0;
    @(negedge clk);
    rst_i        = d_rst;
    id_valid_i   = d_iv;
    id_ack_i     = d_ia;
    id_rd_i      = 5'(d_rd);
    id_rs1_i     = 5'(d_rs1);
    id_rs2_i     = 5'(d_rs2);
    id_we_i      = d_we;
    id_use_rs1_i = d_u1;
    id_use_rs2_i = d_u2;
    id_fence_i   = d_fe;
    ex_valid_i   = d_exv;
    ex_branch_i  = d_br;
    ex_result_i  = d_res;
    mem_ack_i    = d_mack;
    wb_retire_i  = d_ret;
    #1;
    fl = d_exv && d_br && d_mack;
    st = m_stall(d_iv, d_rs1, d_rs2, d_u1, d_u2, d_fe);
    chk("stall", 32'(stall_o), 32'(st));
    chk("flush", 32'(flush_o), 32'(fl));
    chk("redir", 32'(pc_redirect_o), 32'(fl));
    chk("target", pc_target_o, fl ? d_res : 32'd0);
    chk("inflight", 32'(inflight_o), 32'(q.size()));
    if (d_rst) begin
      q.delete();
      nex = 0;
      fst = 0;
    end else begin
      adv  = d_exv && d_mack;
      psh  = d_iv && d_ia && !fl;
      occ0 = q.size();
      pop  = d_ret && occ0 != 0;
      if (fl) begin
        while (q.size() > nex + 1) void'(q.pop_back());
      end else if (psh) begin
        q.push_back('{d_rd, d_we && d_rd != 0});
      end
      if (adv) nex++;
      if (pop) begin
        void'(q.pop_front());
        nex--;
      end
      if (fl) fst = 0;
      else if (!fst) begin
        if (d_iv && d_fe && occ0 != 0) fst = 1;
      end else if (q.size() == 0) fst = 0;
    end
  endtask

  task automatic do_reset();
    idle(); d_rst = 1; step(); step(); idle();
  endtask

  task automatic push_rd(int rd);
    idle(); d_iv = 1; d_ia = 1; d_rd = rd; d_we = 1; step();
  endtask

  initial begin
    q.delete(); nex = 0; fst = 0;
    do_reset();
    step();
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_infl", 32'(inflight_o), 32'd0);

    // RAW on rd=5 held until retire, then released
    push_rd(5);
    idle(); d_iv = 1; d_rs1 = 5; d_u1 = 1; step();
    chk("raw_stall", 32'(stall_o), 32'd1);
    d_exv = 1; d_mack = 1; step();
    d_exv = 0; d_mack = 0; d_ret = 1; step();
    chk("raw_pop_cyc", 32'(stall_o), 32'd1);
    d_ret = 0; step();
    chk("raw_release", 32'(stall_o), 32'd0);
    push_rd(0);
    idle(); d_iv = 1; d_rs1 = 0; d_u1 = 1; step();
    chk("x0_nostall", 32'(stall_o), 32'd0);

    // Full, then one retire
    do_reset();
    for (int i = 1; i <= 4; i++) push_rd(i + 8);
    idle(); d_iv = 1; d_exv = 1; d_mack = 1; step();
    chk("full_infl", 32'(inflight_o), 32'd4);
    chk("full_stall", 32'(stall_o), 32'd1);
    idle(); d_iv = 1; d_ret = 1; step();
    chk("full_pop_stall", 32'(stall_o), 32'd1);
    idle(); d_iv = 1; step();
    chk("pop_infl", 32'(inflight_o), 32'd3);
    chk("pop_release", 32'(stall_o), 32'd0);

    // Taken branch with same-cycle push
    do_reset();
    push_rd(1);
    push_rd(2);
    idle(); d_exv = 1; d_br = 1; d_mack = 1; d_res = 32'h100;
    d_iv = 1; d_ia = 1; d_rd = 3; d_we = 1; step();
    chk("br_target", pc_target_o, 32'h100);
    idle(); step();
    chk("br_infl", 32'(inflight_o), 32'd1);

    // Fence with two in flight
    do_reset();
    push_rd(1);
    push_rd(2);
    idle(); d_exv = 1; d_mack = 1; step(); step();
    idle(); d_iv = 1; d_fe = 1; step();
    chk("fence_stall", 32'(stall_o), 32'd1);
    d_ret = 1; step();
    chk("fence_r1", 32'(stall_o), 32'd1);
    step();
    chk("fence_r2", 32'(stall_o), 32'd1);
    d_ret = 0; step();
    chk("fence_done", 32'(stall_o), 32'd0);

    // Reset with three in flight while in FENCE
    do_reset();
    for (int i = 0; i < 3; i++) push_rd(i + 4);
    idle(); d_iv = 1; d_fe = 1; step();
    step();
    idle(); d_rst = 1; step();
    idle(); d_iv = 1; step();
    chk("rst_fence_infl", 32'(inflight_o), 32'd0);
    chk("rst_fence_stall", 32'(stall_o), 32'd0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      idle();
      d_rst = ($urandom_range(0, 79) == 0);
      d_iv  = ($urandom_range(0, 9) < 7);
      d_rd  = $urandom_range(0, 5);
      d_rs1 = $urandom_range(0, 5);
      d_rs2 = $urandom_range(0, 5);
      d_we  = $urandom_range(0, 3) != 0;
      d_u1  = $urandom_range(0, 1);
      d_u2  = $urandom_range(0, 1);
      d_fe  = ($urandom_range(0, 9) == 0);
      d_ia  = d_iv && $urandom_range(0, 3) != 0 &&
              !m_stall(d_iv, d_rs1, d_rs2, d_u1, d_u2, d_fe);
      if (nex < q.size() && $urandom_range(0, 1) == 1) begin
        d_exv  = 1;
        d_mack = 1;
        d_br   = ($urandom_range(0, 6) == 0);
        d_res  = $urandom;
      end else begin
        d_exv = $urandom_range(0, 3) == 0;
        d_br  = $urandom_range(0, 1);
        d_res = $urandom;
      end
      if (nex > 0) d_ret = $urandom_range(0, 1);
      else if (q.size() == 0) d_ret = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
